// File: rtl/i2c_txn_arbiter.sv
// Two-requester arbiter in front of a single i2c_master: grant, hold fields, pulse start, collect result, guard gap.
// Define I2C_ARB_FIXED_PRIO_EN to make requester 1 win every tie instead of round-robin.
module i2c_txn_arbiter #(
  parameter int GUARD_CYCLES = 16,
  parameter int START_WAIT   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_dev_addr,
  input  logic [7:0] req0_word_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       req0_done,
  output logic [7:0] req0_rdata,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic [7:0] req1_dev_addr,
  input  logic [7:0] req1_word_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       req1_done,
  output logic [7:0] req1_rdata,
  output logic       req1_err,
  output logic [7:0] m_device_addr,
  output logic [7:0] m_word_addr,
  output logic [7:0] m_data_wr,
  output logic       m_start,
  input  logic [7:0] m_rd_data,
  input  logic       m_rd_data_vld,
  input  logic       m_busy,
  output logic       grant_id,
  output logic       arb_busy
);

  localparam int CNT_MAX = (GUARD_CYCLES > START_WAIT) ? GUARD_CYCLES : START_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WAIT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DONE, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             start_fail_reg;
  logic             got_data_reg;
  logic [7:0]       rd_buf_reg;
  logic             do_grant;
  logic             sel;
  logic             txn_err;
`ifndef I2C_ARB_FIXED_PRIO_EN
  logic             last_grant_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    do_grant   = 1'b0;
`ifdef I2C_ARB_FIXED_PRIO_EN
    sel = req1_valid;
`else
    // On a tie, the requester that did not own the previous transaction wins.
    sel = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
`endif
    case (state_reg)
      IDLE: begin
        if ((req0_valid || req1_valid) && !m_busy) begin
          do_grant   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (m_busy)                   state_next = RUN;
        else if (cnt_reg == START_LAST) state_next = DONE;
      end
      RUN:       if (!m_busy) state_next = DONE;
      DONE:      state_next = GAP;
      GAP:       if (cnt_reg == GUARD_LAST) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // A read that never produced data means NACK or master timeout.
  assign txn_err = start_fail_reg | (m_device_addr[0] & ~got_data_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_ready     <= 1'b0;
      req0_done      <= 1'b0;
      req0_rdata     <= 8'h00;
      req0_err       <= 1'b0;
      req1_ready     <= 1'b0;
      req1_done      <= 1'b0;
      req1_rdata     <= 8'h00;
      req1_err       <= 1'b0;
      m_device_addr  <= 8'h00;
      m_word_addr    <= 8'h00;
      m_data_wr      <= 8'h00;
      m_start        <= 1'b0;
      grant_id       <= 1'b0;
      arb_busy       <= 1'b0;
      cnt_reg        <= '0;
      start_fail_reg <= 1'b0;
      got_data_reg   <= 1'b0;
      rd_buf_reg     <= 8'h00;
`ifndef I2C_ARB_FIXED_PRIO_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      m_start    <= 1'b0;
      arb_busy   <= (state_next != IDLE);
      case (state_reg)
        IDLE: begin
          if (do_grant) begin
            m_device_addr  <= sel ? req1_dev_addr  : req0_dev_addr;
            m_word_addr    <= sel ? req1_word_addr : req0_word_addr;
            m_data_wr      <= sel ? req1_wdata     : req0_wdata;
            grant_id       <= sel;
`ifndef I2C_ARB_FIXED_PRIO_EN
            last_grant_reg <= sel;
`endif
            req0_ready     <= ~sel;
            req1_ready     <= sel;
            got_data_reg   <= 1'b0;
            start_fail_reg <= 1'b0;
          end
        end
        ISSUE: begin
          m_start <= 1'b1;
          cnt_reg <= '0;
        end
        WAIT_BUSY: begin
          if (!m_busy) begin
            if (cnt_reg == START_LAST) start_fail_reg <= 1'b1;
            else                       cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          if (m_rd_data_vld) begin
            rd_buf_reg   <= m_rd_data;
            got_data_reg <= 1'b1;
          end
        end
        DONE: begin
          if (grant_id) begin
            req1_done <= 1'b1;
            req1_err  <= txn_err;
            if (m_device_addr[0] && got_data_reg) req1_rdata <= rd_buf_reg;
          end else begin
            req0_done <= 1'b1;
            req0_err  <= txn_err;
            if (m_device_addr[0] && got_data_reg) req0_rdata <= rd_buf_reg;
          end
          cnt_reg <= '0;
        end
        GAP:     cnt_reg <= cnt_reg + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a small behavioural i2c_master model.
module tb_i2c_txn_arbiter;
  localparam int GUARD_CYCLES = 16;
  localparam int START_WAIT   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_dev_addr, req0_word_addr, req0_wdata;
  logic [7:0] req1_dev_addr, req1_word_addr, req1_wdata;
  logic       req0_ready, req0_done, req0_err;
  logic       req1_ready, req1_done, req1_err;
  logic [7:0] req0_rdata, req1_rdata;
  logic [7:0] m_device_addr, m_word_addr, m_data_wr, m_rd_data;
  logic       m_start, m_rd_data_vld, m_busy;
  logic       grant_id, arb_busy;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.GUARD_CYCLES(GUARD_CYCLES), .START_WAIT(START_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_dev_addr(req0_dev_addr), .req0_word_addr(req0_word_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_dev_addr(req1_dev_addr), .req1_word_addr(req1_word_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .m_device_addr(m_device_addr), .m_word_addr(m_word_addr), .m_data_wr(m_data_wr),
    .m_start(m_start), .m_rd_data(m_rd_data), .m_rd_data_vld(m_rd_data_vld),
    .m_busy(m_busy), .grant_id(grant_id), .arb_busy(arb_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  int rdy0_cnt = 0, done0_cnt = 0;
  always @(negedge clk) begin
    if (req0_ready === 1'b1) rdy0_cnt++;
    if (req0_done === 1'b1)  done0_cnt++;
  end

  // Master model: mode 0 busy then idle, 1 busy then data+idle, 2 busy then idle (NACK), 3 never busy
  int         mdl_mode = 0;
  int         mdl_len  = 200;
  logic [7:0] mdl_data = 8'h00;
  initial begin
    m_busy = 1'b0; m_rd_data_vld = 1'b0; m_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (m_start === 1'b1 && mdl_mode != 3) begin
        m_busy = 1'b1;
        repeat (mdl_len) @(negedge clk);
        if (mdl_mode == 1) begin
          m_rd_data     = mdl_data;
          m_rd_data_vld = 1'b1;
        end
        m_busy = 1'b0;
        @(negedge clk);
        m_rd_data_vld = 1'b0;
      end
    end
  end

  // which: 0 req0_ready, 1 req1_ready, 2 req0_done, 3 req1_done, 4 m_start, else any ready
  task automatic wait_sig(input int which, input int limit, output int cyc);
    logic hit;
    cyc = 0;
    hit = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      case (which)
        0:       hit = req0_ready;
        1:       hit = req1_ready;
        2:       hit = req0_done;
        3:       hit = req1_done;
        4:       hit = m_start;
        default: hit = req0_ready | req1_ready;
      endcase
    end while (hit !== 1'b1 && cyc < limit);
    if (hit !== 1'b1) begin
      chk($sformatf("timeout_%0d", which), 32'(hit), 1);
      cyc = -1;
    end
  endtask

  int   cyc, starts, d0, r0;
  logic stable;
  logic exp_g [4];

  initial begin
`ifdef I2C_ARB_FIXED_PRIO_EN
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_dev_addr = 8'h00; req0_word_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_dev_addr = 8'h00; req1_word_addr = 8'h00; req1_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_arb_busy", 32'(arb_busy), 0);
    chk("rst_m_dev", 32'(m_device_addr), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: req0 write, master busy 200 cycles
    mdl_mode = 0; mdl_len = 200;
    req0_dev_addr = 8'hA0; req0_word_addr = 8'h10; req0_wdata = 8'h55; req0_valid = 1'b1;
    wait_sig(0, 5, cyc);
    chk("t1_ready_lat", 32'(cyc), 1);
    req0_valid = 1'b0;
    wait_sig(4, 5, cyc);
    chk("t1_start_lat", 32'(cyc), 1);
    chk("t1_m_dev", 32'(m_device_addr), 32'h A0);
    chk("t1_m_word", 32'(m_word_addr), 32'h10);
    chk("t1_m_data", 32'(m_data_wr), 32'h55);
    chk("t1_arb_busy", 32'(arb_busy), 1);
    stable = 1'b1; starts = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (m_device_addr !== 8'hA0 || m_word_addr !== 8'h10 || m_data_wr !== 8'h55) stable = 1'b0;
      if (m_start === 1'b1) starts++;
    end while (req0_done !== 1'b1 && cyc < 400);
    chk("t1_done_seen", 32'(req0_done), 1);
    chk("t1_m_stable", 32'(stable), 1);
    chk("t1_extra_start", 32'(starts), 0);
    chk("t1_err", 32'(req0_err), 0);

    // T2: req1 read returning 0x3C, launched during the guard gap
    mdl_mode = 1; mdl_len = 20; mdl_data = 8'h3C;
    req1_dev_addr = 8'h91; req1_word_addr = 8'h02; req1_wdata = 8'h00; req1_valid = 1'b1;
    wait_sig(1, 40, cyc);
    chk("t2_gap_to_ready", 32'(cyc), GUARD_CYCLES + 1);
    req1_valid = 1'b0;
    chk("t2_grant_id", 32'(grant_id), 1);
    d0 = done0_cnt;
    wait_sig(3, 200, cyc);
    chk("t2_err", 32'(req1_err), 0);
    chk("t2_rdata", 32'(req1_rdata), 32'h3C);
    chk("t2_req0_rdata", 32'(req0_rdata), 0);
    chk("t2_req0_no_done", 32'(done0_cnt - d0), 0);

    // T3: valid withdrawn before ready gets nothing; then NACKed read
    repeat (2) @(negedge clk);
    r0 = rdy0_cnt;
    req0_valid = 1'b1;
    repeat (5) @(negedge clk);
    req0_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("t3_withdrawn_no_ready", 32'(rdy0_cnt - r0), 0);
    mdl_mode = 2; mdl_len = 10;
    req1_word_addr = 8'h05; req1_valid = 1'b1;
    wait_sig(1, 5, cyc);
    chk("t3_ready_lat", 32'(cyc), 1);
    req1_valid = 1'b0;
    wait_sig(3, 200, cyc);
    chk("t3_nack_err", 32'(req1_err), 1);
    chk("t3_rdata_kept", 32'(req1_rdata), 32'h3C);

    // T4: both requesters valid for four transactions
    repeat (20) @(negedge clk);
    mdl_mode = 0; mdl_len = 5;
    req0_dev_addr = 8'hA0; req0_valid = 1'b1;
    req1_dev_addr = 8'h90; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_sig(5, 80, cyc);
      chk($sformatf("t4_grant%0d", i), 32'(req1_ready), 32'(exp_g[i]));
      chk($sformatf("t4_grant_id%0d", i), 32'(grant_id), 32'(exp_g[i]));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (60) @(negedge clk);

    // T5: master never goes busy -> start failure
    mdl_mode = 3;
    req0_dev_addr = 8'hA2; req0_valid = 1'b1;
    wait_sig(0, 5, cyc);
    req0_valid = 1'b0;
    wait_sig(4, 5, cyc);
    wait_sig(2, 40, cyc);
    chk("t5_start_fail_lat", 32'(cyc), START_WAIT + 1);
    chk("t5_err", 32'(req0_err), 1);

    // T6: reset during RUN, then a pending tie goes to req0
    repeat (30) @(negedge clk);
    mdl_mode = 0; mdl_len = 200;
    req0_dev_addr = 8'hA4; req0_valid = 1'b1;
    wait_sig(0, 5, cyc);
    req0_valid = 1'b0;
    wait_sig(4, 5, cyc);
    repeat (20) @(negedge clk);
    d0 = done0_cnt;
    req0_dev_addr = 8'hA6; req0_valid = 1'b1;
    req1_dev_addr = 8'h92; req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_arb_busy", 32'(arb_busy), 0);
    chk("t6_rst_m_dev", 32'(m_device_addr), 0);
    chk("t6_rst_req0_err", 32'(req0_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_sig(5, 400, cyc);
    chk("t6_first_req0", 32'(req0_ready), 1);
    chk("t6_not_req1", 32'(req1_ready), 0);
    chk("t6_no_done", 32'(done0_cnt - d0), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Shares one i2c_master instance between two requesters:
- req0: periodic sensor poll.
- req1: BMC/host register access.

Each requester posts a single-byte transaction (device addr incl. R/W bit, word addr, write data). The block arbitrates, holds the master's inputs stable for the whole transaction, pulses start, detects completion via the master's busy/rd_data_vld, returns read data and a status, then enforces a bus-idle guard gap before the next grant.

Parameters:
GUARD_CYCLES, 16, clk cycles of enforced idle between end of one transaction and next grant (min 1)
START_WAIT, 8, clk cycles allowed for m_busy to rise after m_start; exceeding it = start failure

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 transaction pending; held with fields until req0_ready seen
req0_dev_addr  in  8  [7:1] 7-bit address, [0] 1=read 0=write
req0_word_addr  in  8  register address
req0_wdata  in  8  write byte (ignored for reads)
req0_ready  out  1  1-cycle pulse: transaction accepted, fields latched
req0_done  out  1  1-cycle pulse: transaction finished
req0_rdata  out  8  read byte, valid with req0_done
req0_err  out  1  status, valid with req0_done
req1_* : identical set for requester 1
m_device_addr  out  8  to master device_addr
m_word_addr  out  8  to master word_addr
m_data_wr  out  8  to master data_wr_in
m_start  out  1  to master start, 1-cycle pulse
m_rd_data  in  8  from master rd_data
m_rd_data_vld  in  1  from master rd_data_vld
m_busy  in  1  from master i2c_busy
grant_id  out  1  requester owning current/last transaction
arb_busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset: state=IDLE.
  - All outputs 0: m_* regs, readies, dones, rdata, err, grant_id, arb_busy.
  - last_grant=1, so req0 wins the first tie.
  - Reset mid-transaction aborts with no done pulse; the master's own timeout/idle recovers the bus.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, RUN, DONE, GAP.
- IDLE:
  - Grant only if some reqN_valid=1 and m_busy=0.
  - Selection: single valid wins. Both valid → the one != last_grant (round-robin).
  - Next cycle: latch fields into m_*, set grant_id/last_grant, pulse reqN_ready, clear got_data, → ISSUE.
- ISSUE: m_start=1 for exactly this cycle; cnt=0 → WAIT_BUSY.
- WAIT_BUSY:
  - m_busy=1 → RUN.
  - Else if cnt==START_WAIT-1 → DONE with start_fail=1.
  - Else cnt++.
- RUN:
  - On m_rd_data_vld: capture m_rd_data into rdata of the granted requester, got_data=1.
  - m_busy=0 → DONE.
  - If vld and busy-fall occur in the same cycle, the data is captured.
- DONE:
  - Pulse reqN_done for 1 cycle on the granted requester only.
  - err = start_fail | (dev_addr[0] & ~got_data), covering NACK and master 31 ms timeout.
  - Writes report err=start_fail only.
  - rdata holds until that requester's next done. For writes it is unchanged.
  - cnt=0 → GAP.
- GAP: count GUARD_CYCLES, then → IDLE.
- m_device_addr/m_word_addr/m_data_wr remain stable from ISSUE through GAP; the master samples them combinationally throughout.
- req valid deasserting before ready: no grant, no error.
- valid still high the cycle after ready is not re-sampled (FSM not in IDLE).
- Grant latency: valid in IDLE → ready at +1 cycle, m_start at +2 cycles.

Optional Feature:
I2C_ARB_FIXED_PRIO_EN:
- Defined: requester 1 always wins when both are valid; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- req0 write dev=0xA0 word=0x10 wdata=0x55, master model busy for 200 cycles → req0_ready at +1, m_start single pulse at +2, m_* stable throughout, req0_done with err=0, then 16 idle cycles before any new grant.
- req1 read dev=0x91 word=0x02, model returns vld with 0x3C then busy falls → req1_done, req1_rdata=0x3C, err=0; req0 outputs untouched.
- req1 read where model drops busy with no vld (NACK) → req1_done, err=1, req1_rdata retains previous 0x3C.
- Both valid continuously for 4 transactions → grants 0,1,0,1. With I2C_ARB_FIXED_PRIO_EN: 1,1,1,1.
- Model never raises busy → done and err=1 exactly START_WAIT=8 cycles after WAIT_BUSY entry.
- Async rst_n asserted during RUN → all outputs 0 immediately, no done pulse; after release, a pending req0 is granted first.
